// File: rtl/code_memory_loader_pkg.sv
// ---------------------------------------------------------------------------
// code_memory_loader_pkg
// Shared definitions for the code-memory loader: FSM state encoding, the
// error codes reported on oErrCode, and the default .text base address.
// ---------------------------------------------------------------------------
package code_memory_loader_pkg;

    // First .text address of the target memory map
    localparam logic [31:0] BEGINNING_TEXT = 32'h0040_0000;

    // Values driven on oErrCode
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_VERIFY  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEN       = 3'd1,
        ST_DATA      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_VERIFY_RD = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } loader_state_t;

endpackage

// File: rtl/code_memory_loader_byte_word_assembler.sv
// ---------------------------------------------------------------------------
// code_memory_loader_byte_word_assembler
// Collects stream bytes LSB-first into a 32-bit little-endian word.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear       drop any partial word and restart the byte count
//   take        a byte is transferred this cycle
//   byte_in     the byte being transferred
//   word_out    the completed word (valid together with word_valid)
//   word_valid  high in the cycle the 4th byte of a word is transferred
// ---------------------------------------------------------------------------
module code_memory_loader_byte_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [31:0] word_q, word_d;
    logic [1:0]  count_q, count_d;

    // New bytes enter at the top so that after four shifts the first byte
    // received sits in bits [7:0]. The count wraps naturally after a word.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (clear) begin
            word_d  = 32'h0;
            count_d = 2'd0;
        end else if (take) begin
            word_d  = {byte_in, word_q[31:8]};
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= 32'h0;
            count_q <= 2'd0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word_out   = {byte_in, word_q[31:8]};
    assign word_valid = take && !clear && (count_q == 2'd3);

endmodule

// File: rtl/code_memory_loader.sv
// ---------------------------------------------------------------------------
// code_memory_loader
// Programs the .text code memory from a byte stream: a 4-byte little-endian
// length header followed by the payload. Each assembled word is written with
// a single-cycle bus write starting at BASE_ADDR; optionally the region is
// read back and its sum compared against the running write checksum.
// Ports:
//   iCLK, iRST                      clock, synchronous active-high reset
//   iStart                          start pulse (honoured in IDLE/DONE/ERR)
//   iByte, iByteValid, oByteReady   byte stream handshake
//   oReadEnable, oWriteEnable,
//   oByteEnable, oAddress,
//   oWriteData, iReadData           code-memory bus (outputs registered)
//   oBusy, oDone, oError, oErrCode  load status
//   oChecksum                       modulo-2^32 sum of words written
// ---------------------------------------------------------------------------
module code_memory_loader
    import code_memory_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BEGINNING_TEXT,
    parameter int unsigned MAX_BYTES    = 16384,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          VERIFY       = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [7:0]  iByte,
    input  logic        iByteValid,
    output logic        oByteReady,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    input  logic [31:0] iReadData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [1:0]  oErrCode,
    output logic [31:0] oChecksum
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);
    localparam logic [7:0]  LAT     = 8'(READ_LATENCY);

    loader_state_t state_q, state_d;
    logic [31:0]   length_q, length_d;
    logic [31:0]   word_idx_q, word_idx_d;
    logic [31:0]   rd_idx_q, rd_idx_d;
    logic [7:0]    lat_q, lat_d;
    logic [31:0]   checksum_q, checksum_d;
    logic [31:0]   vsum_q, vsum_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          write_en_q, write_en_d;
    logic          read_en_q, read_en_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          byte_ready;
    logic          take;
    logic          asm_clear;
    logic [31:0]   asm_word;
    logic          asm_valid;
    logic [31:0]   num_words;
    logic [31:0]   vsum_next;
    logic          len_bad;

    assign byte_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign take       = iByteValid && byte_ready;
    assign num_words  = length_q >> 2;
    assign vsum_next  = vsum_q + iReadData;
    assign len_bad    = (asm_word == 32'h0) || (asm_word[1:0] != 2'b00) ||
                        (asm_word > MAX_LEN);

    code_memory_loader_byte_word_assembler u_asm (
        .clk        (iCLK),
        .rst        (iRST),
        .clear      (asm_clear),
        .take       (take),
        .byte_in    (iByte),
        .word_out   (asm_word),
        .word_valid (asm_valid)
    );

    // Next-state logic. Bus strobes/address/data are computed one cycle
    // ahead so that they come straight out of flops in WRITE / VERIFY_RD.
    // Each read address is held for LAT cycles; iReadData is then sampled
    // in the following cycle while the strobe is dropped.
    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        word_idx_d = word_idx_q;
        rd_idx_d   = rd_idx_q;
        lat_d      = lat_q;
        checksum_d = checksum_q;
        vsum_d     = vsum_q;
        err_code_d = err_code_q;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        addr_d     = 32'h0;
        wdata_d    = 32'h0;
        asm_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (iStart) begin
                    state_d    = ST_LEN;
                    asm_clear  = 1'b1;
                    length_d   = 32'h0;
                    word_idx_d = 32'h0;
                    rd_idx_d   = 32'h0;
                    lat_d      = 8'h0;
                    checksum_d = 32'h0;
                    vsum_d     = 32'h0;
                    err_code_d = ERR_NONE;
                end
            end
            ST_LEN: begin
                if (asm_valid) begin
                    length_d = asm_word;
                    if (len_bad) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_BAD_LEN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (asm_valid) begin
                    state_d    = ST_WRITE;
                    write_en_d = 1'b1;
                    addr_d     = BASE_ADDR + (word_idx_q << 2);
                    wdata_d    = asm_word;
                end
            end
            ST_WRITE: begin
                checksum_d = checksum_q + wdata_q;
                word_idx_d = word_idx_q + 32'd1;
                if ((word_idx_q + 32'd1) == num_words) begin
                    if (VERIFY) begin
                        state_d   = ST_VERIFY_RD;
                        read_en_d = 1'b1;
                        addr_d    = BASE_ADDR;
                        rd_idx_d  = 32'h0;
                        lat_d     = 8'h0;
                        vsum_d    = 32'h0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_VERIFY_RD: begin
                if (lat_q == LAT) begin
                    vsum_d   = vsum_next;
                    rd_idx_d = rd_idx_q + 32'd1;
                    lat_d    = 8'h0;
                    if ((rd_idx_q + 32'd1) == num_words) begin
                        if (vsum_next == checksum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_VERIFY;
                        end
                    end else begin
                        read_en_d = 1'b1;
                        addr_d    = BASE_ADDR + ((rd_idx_q + 32'd1) << 2);
                    end
                end else begin
                    lat_d = lat_q + 8'd1;
                    if (lat_q != (LAT - 8'd1)) begin
                        read_en_d = 1'b1;
                        addr_d    = addr_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including
    // a load that is half-way through writing or verifying.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            length_q   <= 32'h0;
            word_idx_q <= 32'h0;
            rd_idx_q   <= 32'h0;
            lat_q      <= 8'h0;
            checksum_q <= 32'h0;
            vsum_q     <= 32'h0;
            err_code_q <= ERR_NONE;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            word_idx_q <= word_idx_d;
            rd_idx_q   <= rd_idx_d;
            lat_q      <= lat_d;
            checksum_q <= checksum_d;
            vsum_q     <= vsum_d;
            err_code_q <= err_code_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign oByteReady   = byte_ready;
    assign oReadEnable  = read_en_q;
    assign oWriteEnable = write_en_q;
    assign oByteEnable  = (write_en_q || read_en_q) ? 4'hF : 4'h0;
    assign oAddress     = addr_q;
    assign oWriteData   = wdata_q;
    assign oBusy        = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                          (state_q == ST_WRITE) || (state_q == ST_VERIFY_RD);
    assign oDone        = (state_q == ST_DONE);
    assign oError       = (state_q == ST_ERR);
    assign oErrCode     = err_code_q;
    assign oChecksum    = checksum_q;

endmodule

// File: tb/tb_code_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_code_memory_loader
// Scoreboard bench for code_memory_loader with a behavioural memory model.
// ---------------------------------------------------------------------------
module tb_code_memory_loader;
    import code_memory_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          MAXB = 16384;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [31:0] sum;
    } st_t;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oReadEnable;
    logic        oWriteEnable;
    logic [3:0]  oByteEnable;
    logic [31:0] oAddress;
    logic [31:0] oWriteData;
    logic [31:0] iReadData;
    logic        oBusy;
    logic        oDone;
    logic        oError;
    logic [1:0]  oErrCode;
    logic [31:0] oChecksum;

    int          nChecks = 0;
    int          nPass   = 0;
    int          corruptIdx = -1;
    logic        prevFin = 1'b0;
    wr_t         expWr[$];
    st_t         expSt[$];
    logic [7:0]  payload[$];
    logic [31:0] mem [0:4095];
    logic [31:0] rdata;
    logic [31:0] busOff;

    code_memory_loader #(
        .BASE_ADDR    (BASE),
        .MAX_BYTES    (MAXB),
        .READ_LATENCY (1),
        .VERIFY       (1'b1)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iStart       (iStart),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteReady   (oByteReady),
        .oReadEnable  (oReadEnable),
        .oWriteEnable (oWriteEnable),
        .oByteEnable  (oByteEnable),
        .oAddress     (oAddress),
        .oWriteData   (oWriteData),
        .iReadData    (iReadData),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oError       (oError),
        .oErrCode     (oErrCode),
        .oChecksum    (oChecksum)
    );

    // Free-running clock
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Synchronous code memory; corruptIdx flips bits of one word on read
    assign busOff    = (oAddress - BASE) >> 2;
    assign iReadData = rdata;
    always @(posedge iCLK) begin
        if (oWriteEnable) mem[busOff[11:0]] <= oWriteData;
        if (oReadEnable)
            rdata <= mem[busOff[11:0]] ^ ((busOff == 32'(corruptIdx)) ? 32'hDEAD_BEEF : 32'h0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        nChecks++;
        $display("[TB] FAIL %s: event not expected or not seen", name);
    endtask

    // Monitor: pops expected writes on every write strobe and expected
    // status on every rising edge of done/error
    always @(negedge iCLK) begin
        if (iRST) begin
            prevFin = 1'b0;
        end else begin
            if (oWriteEnable) begin
                checkOutput("wr_be", {28'h0, oByteEnable}, 32'hF);
                checkOutput("wr_no_rd", {31'h0, oReadEnable}, 32'h0);
                if (expWr.size() == 0) failNow("unexpected_write");
                else begin
                    wr_t w;
                    w = expWr.pop_front();
                    checkOutput("wr_addr", oAddress, w.addr);
                    checkOutput("wr_data", oWriteData, w.data);
                end
            end
            if (oReadEnable) checkOutput("rd_be", {28'h0, oByteEnable}, 32'hF);
            if ((oDone || oError) && !prevFin) begin
                if (expSt.size() == 0) failNow("unexpected_finish");
                else begin
                    st_t s;
                    s = expSt.pop_front();
                    checkOutput("st_done", {31'h0, oDone}, {31'h0, s.done});
                    checkOutput("st_err", {31'h0, oError}, {31'h0, s.err});
                    checkOutput("st_code", {30'h0, oErrCode}, {30'h0, s.code});
                    checkOutput("st_sum", oChecksum, s.sum);
                    checkOutput("st_writes_drained", 32'(expWr.size()), 32'h0);
                end
                checkOutput("st_not_busy", {31'h0, oBusy}, 32'h0);
            end
            prevFin = oDone || oError;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, {31'h0, oByteReady}, 32'h0);
        checkOutput({tag, "_rd"}, {31'h0, oReadEnable}, 32'h0);
        checkOutput({tag, "_wr"}, {31'h0, oWriteEnable}, 32'h0);
        checkOutput({tag, "_be"}, {28'h0, oByteEnable}, 32'h0);
        checkOutput({tag, "_addr"}, oAddress, 32'h0);
        checkOutput({tag, "_wdata"}, oWriteData, 32'h0);
        checkOutput({tag, "_busy"}, {31'h0, oBusy}, 32'h0);
        checkOutput({tag, "_done"}, {31'h0, oDone}, 32'h0);
        checkOutput({tag, "_error"}, {31'h0, oError}, 32'h0);
        checkOutput({tag, "_code"}, {30'h0, oErrCode}, 32'h0);
        checkOutput({tag, "_sum"}, oChecksum, 32'h0);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred
    task automatic sendByte(input logic [7:0] b, input int gapMode);
        int guard = 0;
        iByte = b;
        iByteValid = 1'b1;
        while (!oByteReady && guard < 1000) begin
            @(negedge iCLK);
            guard++;
        end
        if (guard >= 1000) failNow("byte_ready_timeout");
        else checkOutput("busy_while_ready", {31'h0, oBusy}, 32'h1);
        @(negedge iCLK);
        iByteValid = 1'b0;
        iByte = 8'h00;
        if (gapMode == 1) @(negedge iCLK);
        else if (gapMode == 2) repeat ($urandom_range(0, 2)) @(negedge iCLK);
    endtask

    task automatic pulseStart();
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
    endtask

    task automatic waitFinish();
        int guard = 0;
        while (!(oDone || oError) && guard < 2000) begin
            @(negedge iCLK);
            guard++;
        end
        if (guard >= 2000) failNow("finish_timeout");
        @(negedge iCLK);
    endtask

    // Reference model: the header decides accept/reject; accepted loads
    // produce one write per little-endian word and a sum of those words.
    task automatic applyStimulus(input logic [31:0] lenHdr, input int gapMode, input int corrupt);
        logic [31:0] sum;
        logic [31:0] w;
        int          nWords;
        bit          bad;
        bad = (lenHdr == 0) || (lenHdr % 4 != 0) || (lenHdr > MAXB);
        corruptIdx = corrupt;
        if (bad) begin
            expSt.push_back('{1'b0, 1'b1, ERR_BAD_LEN, 32'h0});
        end else begin
            nWords = int'(lenHdr / 4);
            sum = 32'h0;
            for (int i = 0; i < nWords; i++) begin
                w = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
                expWr.push_back('{BASE + 32'(4*i), w});
                sum = sum + w;
            end
            if (corrupt >= 0 && corrupt < nWords) expSt.push_back('{1'b0, 1'b1, ERR_VERIFY, sum});
            else expSt.push_back('{1'b1, 1'b0, ERR_NONE, sum});
        end
        pulseStart();
        for (int b = 0; b < 4; b++) sendByte(lenHdr[8*b +: 8], gapMode);
        if (!bad) for (int i = 0; i < int'(lenHdr); i++) sendByte(payload[i], gapMode);
        waitFinish();
    endtask

    task automatic randomPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        logic [31:0] rlen;
        iRST = 1'b1;
        iStart = 1'b0;
        iByte = 8'h00;
        iByteValid = 1'b0;
        repeat (3) @(negedge iCLK);
        checkAllZero("reset");
        iRST = 1'b0;
        @(negedge iCLK);

        // Two-instruction program
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        applyStimulus(32'd8, 0, -1);
        checkOutput("prog_checksum", oChecksum, 32'h0010_00A6);

        // Bad lengths: not a multiple of 4, zero, and one word too long
        applyStimulus(32'd6, 0, -1);
        applyStimulus(32'd0, 0, -1);
        applyStimulus(32'(MAXB + 4), 0, -1);

        // Read-back of word 1 corrupted
        randomPayload(8);
        applyStimulus(32'd8, 0, 1);

        // Valid toggling every cycle with a 16-byte payload
        randomPayload(16);
        applyStimulus(32'd16, 1, -1);

        // Reset in the middle of the payload
        randomPayload(8);
        pulseStart();
        for (int b = 0; b < 4; b++) sendByte(8'(b == 0 ? 8 : 0), 0);
        sendByte(payload[0], 0);
        sendByte(payload[1], 0);
        iRST = 1'b1;
        @(negedge iCLK);
        checkAllZero("midreset");
        iRST = 1'b0;
        @(negedge iCLK);
        applyStimulus(32'd8, 0, -1);

        // Randomized loads
        for (int k = 0; k < 8; k++) begin
            rlen = 32'(4 * $urandom_range(1, 12));
            if ($urandom_range(0, 5) == 0) rlen = rlen + 32'($urandom_range(1, 3));
            randomPayload(int'(rlen));
            applyStimulus(rlen, int'($urandom_range(0, 2)),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1);
        end

        repeat (5) @(negedge iCLK);
        checkOutput("final_wr_queue", 32'(expWr.size()), 32'h0);
        checkOutput("final_st_queue", 32'(expSt.size()), 32'h0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/code_memory_loader.md
Name: code_memory_loader

Overview:
- Bus initiator that programs the .text code memory from a byte stream, e.g. a UART boot path.
- Receives a 4-byte length header, then payload bytes. Assembles little-endian 32-bit words and issues one write cycle per word on the code-memory IO bus, starting at BASE_ADDR.
- Optionally reads the region back and compares a running checksum, so the boot path gets a pass/fail before releasing the core.

Parameters:
- BASE_ADDR, 32'h0040_0000, first .text address written (BEGINNING_TEXT).
- MAX_BYTES, 16384, largest accepted payload; must be a multiple of 4.
- READ_LATENCY, 1, iCLK cycles from read address to valid iReadData (synchronous memory).
- VERIFY, 1, 1 = read-back check after programming; 0 = skip.

Ports:
- iCLK  in  1  system clock; everything is on the rising edge.
- iRST  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse; begins a load, accepted only in IDLE/DONE/ERR.
- iByte  in  8  stream byte.
- iByteValid  in  1  iByte is valid this cycle.
- oByteReady  out  1  loader accepts iByte this cycle; a transfer is iByteValid && oByteReady.
- oReadEnable  out  1  bus read strobe.
- oWriteEnable  out  1  bus write strobe, exactly one cycle per word.
- oByteEnable  out  4  always 4'b1111 during a bus access, else 0.
- oAddress  out  32  bus address.
- oWriteData  out  32  bus write data.
- iReadData  in  32  bus read data.
- oBusy  out  1  load in progress.
- oDone  out  1  load finished OK; level, held until next iStart or iRST.
- oError  out  1  load failed; level, held until next iStart or iRST.
- oErrCode  out  2  0 = none, 1 = bad length, 2 = verify mismatch.
- oChecksum  out  32  modulo-2^32 sum of all words written.

Behaviour:
- Reset: state IDLE. All outputs 0. Counters, word buffer and checksum cleared. iRST overrides everything, including mid-write and mid-verify. A partially written memory is left as-is.
- IDLE: oByteReady = 0. iStart -> LEN, clear byte counter, word buffer, checksum, oDone, oError, oErrCode.
- LEN: oByteReady = 1. Take 4 bytes LSB-first into a 32-bit length.
  - After the 4th byte: length == 0, length[1:0] != 0, or length > MAX_BYTES -> ERR, oErrCode = 1.
  - Otherwise -> DATA.
- DATA: oByteReady = 1. Shift bytes in LSB-first. On the 4th byte of a word -> WRITE. No bus access while assembling.
- WRITE: one cycle, oByteReady = 0.
  - oWriteEnable = 1, oByteEnable = 4'hF, oAddress = BASE_ADDR + 4*wordIdx, oWriteData = assembled word.
  - checksum += word; wordIdx++.
  - Next state: if words written == length/4 -> VERIFY_RD if VERIFY else DONE; else DATA.
- Bytes arriving while oByteReady = 0 are not consumed; the source holds them.
- Throughput: at most one byte per cycle; one stall cycle per word.
- VERIFY_RD:
  - oReadEnable = 1 and oAddress = BASE_ADDR + 4*rdIdx held for READ_LATENCY cycles.
  - iReadData is sampled on the cycle READ_LATENCY after the address first appears, then added to vsum.
  - Repeat for all words. oReadEnable returns to 0 between words is allowed but not required.
- After the last read: vsum == checksum -> DONE, else ERR with oErrCode = 2.
- DONE / ERR: bus outputs 0, oBusy = 0. iStart restarts (-> LEN with all status cleared).
- oBusy = 1 in LEN, DATA, WRITE and VERIFY_RD.
- iStart while busy is ignored.
- oReadEnable and oWriteEnable are never high in the same cycle.
- Address arithmetic is 32-bit and never wraps, because it is bounded by MAX_BYTES.
- Bus outputs are registered, with no combinational path from iByte.

Decomposition:
- Shared package: state enum (IDLE, LEN, DATA, WRITE, VERIFY_RD, DONE, ERR), error-code constants, BEGINNING_TEXT default.
- One natural sub-module, byte_word_assembler: 4-byte little-endian shift register with byte counter and word_valid pulse. It is reused by LEN and DATA.

Test Plan:
- Header 08 00 00 00, payload 13 00 00 00 93 00 10 00 -> writes 32'h00000013 @0x00400000 and 32'h00100093 @0x00400004. Each oWriteEnable is 1 cycle. oDone = 1, oChecksum = 32'h001000A6.
- Header 06 00 00 00 -> ERR, oErrCode = 1, zero write strobes.
- Header length MAX_BYTES+4 -> ERR, oErrCode = 1.
- Length 8 with VERIFY = 1, model memory corrupts word 1 on read -> ERR, oErrCode = 2, oDone = 0.
- iByteValid toggling 1/0 every cycle with a 16-byte payload -> still exactly 4 writes at consecutive addresses. No byte is lost or duplicated.
- iRST asserted in DATA after 2 of 8 payload bytes -> next cycle all outputs 0, state IDLE. A new iStart with an 8-byte payload completes with oDone = 1.
